io_spi_regbank: RTL
===================

Name: io_spi_regbank

Overview:
- SPI target (mode 0) on the user-area GPIO pins; the user_proj_example core instantiates it to own io_in/io_out/io_oeb.
- An external host writes two 8-bit output registers that drive GPIO pads, and reads back pad inputs and a fixed ID.
- All SPI pins are oversampled in the wb_clk_i domain. No SPI clock is used as an RTL clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per SPI input (min 2)
- ID_VALUE, 8'hA5, constant returned by register 3

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  synchronous active-high reset
- io_in  input  38  pad inputs: [8]=SCK, [9]=CSN, [10]=MOSI, [35:28]=readback pins
- io_out  output  38  pad outputs: [11]=MISO, [19:12]=reg0, [27:20]=reg1, all others 0
- io_oeb  output  38  pad output enables, active low

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: reg0=0, reg1=0, MISO=0, state=IDLE, bit counter=0, shift register=0. All io_out bits are 0 during and after reset.
- io_oeb (combinational):
  - [11] = CSN_sync, so MISO is driven only while selected.
  - [27:12] = 0.
  - All other bits = 1.
- Synchronization: SCK, CSN and MOSI each pass through SYNC_STAGES flops.
  - SCK rise = sck_s & ~sck_d; SCK fall = ~sck_s & sck_d (sck_d is one further flop).
  - The host must keep SCK high and low phases at least 4 wb_clk_i cycles each.
- Frame format: 16 bits, MSB first, MOSI sampled on SCK rise.
  - Byte 0 = {rw, 5'bx, addr[1:0]}; rw=1 means read.
  - Byte 1 = write data, or read data driven on MISO.
- State machine:
  - IDLE: CSN_sync falls → CMD, bit counter=0.
  - CMD: each SCK rise shifts MOSI in, counter+1.
    - At the 8th rise, latch rw and addr. For reads, also snapshot the read value: reg0, reg1, io_in[35:28] (synchronized) or ID_VALUE.
    - Then → DATA.
  - DATA, MISO:
    - On the first SCK fall in DATA, MISO = snapshot[7].
    - On each following fall, shift out the next bit.
    - During CMD, MISO=0.
  - DATA, MOSI: each SCK rise shifts MOSI in, counter+1.
    - At the 16th rise with rw=0 and addr=0 or 1, the write lands in reg0/reg1 on the next clock edge.
    - Writes to addr 2 or 3 are silently dropped.
    - → DONE.
  - DONE: all further SCK edges are ignored (frames longer than 16 bits are harmless); MISO holds 0.
  - Any state: CSN_sync rising → IDLE, counter=0, MISO=0.
    - An incomplete frame causes no register change.
    - CSN rising in the same cycle as the 16th rise: the write still commits.
- Latency: io_out reflects written data SYNC_STAGES+1 wb_clk_i edges after the first edge that samples the 16th SCK high.
- Back-to-back frames: CSN must go high for at least SYNC_STAGES+2 cycles between frames. A CSN fall is detected only from IDLE.
- Reset mid-frame: wb_rst_i wins over every SPI event in the same cycle.
  - Registers clear and state → IDLE.
  - The frame in progress is discarded even if CSN stays low. The next CSN fall starts a new frame.
- Counter width: 5 bits; it saturates at 16 in DONE and does not wrap.

Test Plan:
- Write: CSN low, send 0x00 then 0x3C, CSN high → io_out[19:12]=0x3C, io_out[27:20]=0x00, io_oeb[19:12]=0.
- Read ID: send 0x83 then 8 dummy bits → MISO shifts 1010_0101 (0xA5) on the byte-1 rises; io_oeb[11]=0 only while CSN low.
- Read pins: hold io_in[35:28]=0x5A, send 0x82, then change io_in to 0xFF during byte 1 → MISO returns 0x5A (snapshot taken at the 8th rise).
- Abort: write to reg1 with 0xC3 but raise CSN after 12 bits → reg1 stays at its prior value; the next full write of 0x01 to reg1 gives io_out[27:20]=0x01.
- Illegal and long frames: write 0x77 to addr 3 → read back still 0xA5. A 24-bit frame writing 0x81 to reg0 with trailing 0xFF → reg0=0x81.
- Reset: assert wb_rst_i for 1 cycle after bit 10 of a reg0 write of 0xFF → io_out=0 and reg0 stays 0x00. A fresh frame after CSN high→low writes correctly.

Source files
------------

// File: rtl/io_spi_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : io_spi_regbank
//  Purpose  : Mode-0 SPI target on the user GPIO pads. Two 8-bit output
//             registers, pad readback and a fixed ID, all SPI pins
//             oversampled in the wb_clk_i domain.
//  Revision : 1.0  initial release
// ============================================================================
module io_spi_regbank #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0]   r_sck_sync;
    logic [SYNC_STAGES-1:0]   r_csn_sync;
    logic [SYNC_STAGES-1:0]   r_mosi_sync;
    logic [SYNC_STAGES*8-1:0] r_pin_sync;
    logic                     r_sck_d;
    logic                     r_csn_d;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_snap;
    logic        r_miso;
    logic        r_rw;
    logic [1:0]  r_addr;
    logic        r_wr_pend;
    logic        r_wr_sel;
    logic [7:0]  r_wr_data;
    logic [7:0]  r_reg0;
    logic [7:0]  r_reg1;

    logic        w_sck_s;
    logic        w_csn_s;
    logic        w_mosi_s;
    logic [7:0]  w_pins_s;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_csn_rise;
    logic        w_csn_fall;
    logic [7:0]  w_rd_value;
    logic        w_unused;

    // Synchronizers are left out of reset so a CSN held low across a reset
    // does not look like a fresh falling edge afterwards.
    always_ff @(posedge wb_clk_i) begin
        r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], io_in[8]};
        r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], io_in[9]};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_in[10]};
        r_pin_sync  <= {r_pin_sync[(SYNC_STAGES-1)*8-1:0], io_in[35:28]};
        r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        r_csn_d     <= r_csn_sync[SYNC_STAGES-1];
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_csn_s    = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_pins_s   = r_pin_sync[SYNC_STAGES*8-1 -: 8];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_csn_rise = w_csn_s & ~r_csn_d;
    assign w_csn_fall = ~w_csn_s & r_csn_d;

    // Address bits are the last two command bits: shift[0] plus the bit now on MOSI.
    always_comb begin
        w_rd_value = ID_VALUE;
        case ({r_shift[0], w_mosi_s})
            2'd0:    w_rd_value = r_reg0;
            2'd1:    w_rd_value = r_reg1;
            2'd2:    w_rd_value = w_pins_s;
            default: w_rd_value = ID_VALUE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 5'd0;
            r_shift   <= 8'h00;
            r_snap    <= 8'h00;
            r_miso    <= 1'b0;
            r_rw      <= 1'b0;
            r_addr    <= 2'd0;
            r_wr_pend <= 1'b0;
            r_wr_sel  <= 1'b0;
            r_wr_data <= 8'h00;
            r_reg0    <= 8'h00;
            r_reg1    <= 8'h00;
        end else begin
            r_wr_pend <= 1'b0;
            if (r_wr_pend) begin
                if (r_wr_sel) begin
                    r_reg1 <= r_wr_data;
                end else begin
                    r_reg0 <= r_wr_data;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_csn_fall) begin
                        r_state <= ST_CMD;
                        r_cnt   <= 5'd0;
                        r_shift <= 8'h00;
                        r_miso  <= 1'b0;
                    end
                end
                ST_CMD: begin
                    r_miso <= 1'b0;
                    if (w_sck_rise) begin
                        r_shift <= {r_shift[6:0], w_mosi_s};
                        r_cnt   <= r_cnt + 5'd1;
                        if (r_cnt == 5'd7) begin
                            r_rw    <= r_shift[6];
                            r_addr  <= {r_shift[0], w_mosi_s};
                            r_snap  <= r_shift[6] ? w_rd_value : 8'h00;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sck_fall) begin
                        r_miso <= r_snap[7];
                        r_snap <= {r_snap[6:0], 1'b0};
                    end
                    if (w_sck_rise) begin
                        r_shift <= {r_shift[6:0], w_mosi_s};
                        r_cnt   <= r_cnt + 5'd1;
                        if (r_cnt == 5'd15) begin
                            r_state <= ST_DONE;
                            r_miso  <= 1'b0;
                            // Commit is staged one cycle so it survives a same-cycle CSN rise.
                            if (!r_rw && !r_addr[1]) begin
                                r_wr_pend <= 1'b1;
                                r_wr_sel  <= r_addr[0];
                                r_wr_data <= {r_shift[6:0], w_mosi_s};
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_miso <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_csn_rise && r_state != ST_IDLE) begin
                r_state <= ST_IDLE;
                r_cnt   <= 5'd0;
                r_miso  <= 1'b0;
            end
        end
    end

    assign io_out = {10'b0, r_reg1, r_reg0, r_miso, 11'b0};
    assign io_oeb = {10'h3FF, 16'h0000, w_csn_s, 11'h7FF};

    assign w_unused = ^{io_in[37:36], io_in[27:11], io_in[7:0], r_shift[7]};

endmodule
`default_nettype wire
